obi_mem_arbiter: RTL
====================

# obi_mem_arbiter

Two-to-one OBI arbiter that lets the cv32e40p instruction and data interfaces share one single-ported memory. Forwards one request per cycle to the memory port and arbitrates round-robin between the two requesters. Holds the selected request stable until the memory grants it. Routes in-order memory responses back to the originating requester using an owner-tag FIFO. Sits between `cv32e40p_core` and the core-local RAM model in the test and FPGA tops.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width on all ports
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8
- MAX_OUTSTANDING, 2, granted-but-unanswered requests allowed (≥1); sets owner FIFO depth

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk_i  in  1  clock
  - rst_ni  in  1  async reset, active low
- Instruction requester:
  - instr_req_i  in  1  instruction request
  - instr_gnt_o  out  1  instruction request accepted
  - instr_rvalid_o  out  1  instruction read data valid
  - instr_addr_i  in  ADDR_WIDTH  fetch address
  - instr_rdata_o  out  DATA_WIDTH  fetch data
- Data requester:
  - data_req_i  in  1  data request
  - data_gnt_o  out  1  data request accepted
  - data_rvalid_o  out  1  data response valid
  - data_we_i  in  1  write enable
  - data_be_i  in  DATA_WIDTH/8  byte enables
  - data_addr_i  in  ADDR_WIDTH  data address
  - data_wdata_i  in  DATA_WIDTH  write data
  - data_rdata_o  out  DATA_WIDTH  read data
- Memory port:
  - mem_req_o  out  1  request to memory
  - mem_gnt_i  in  1  memory accepted request
  - mem_rvalid_i  in  1  memory response valid (in order)
  - mem_we_o  out  1  write enable
  - mem_be_o  out  DATA_WIDTH/8  byte enables
  - mem_addr_o  out  ADDR_WIDTH  address
  - mem_wdata_o  out  DATA_WIDTH  write data
  - mem_rdata_i  in  DATA_WIDTH  read data

## Operation
- **FSM states:** ARB_IDLE, ARB_HOLD_INSTR, ARB_HOLD_DATA. Reset state is ARB_IDLE.
- **ARB_IDLE:**
  - Owner is the only requester asserting req.
  - If both assert req, owner is the one indicated by the priority bit `prio_q`. Reset value of `prio_q` is INSTR first.
- **HOLD states:** owner is fixed to the held requester, whatever the other requester does.
- **Issue rule:** mem_req_o = owner req && (count_q < MAX_OUTSTANDING).
- **Memory-port muxing:**
  - Memory-side fields are muxed from the owner.
  - Instruction owner drives mem_we_o=0, mem_be_o=all ones, mem_wdata_o=0.
- **Grant and transitions:**
  - Grant is mem_gnt_i && mem_req_o, steered to the owner's gnt_o only.
  - On grant: push owner tag, set `prio_q` to the other requester, next state ARB_IDLE.
  - mem_req_o && !mem_gnt_i moves to HOLD of the owner.
  - If the held requester drops req (OBI violation), return to ARB_IDLE with no grant. An assertion fires.
- **Response routing:**
  - On mem_rvalid_i, pop the head tag and pulse the matching rvalid_o.
  - mem_rdata_i is driven to both rdata_o unconditionally.
  - mem_rvalid_i while the FIFO is empty is a protocol error: no rvalid_o, count stays 0, assertion fires.
- **Counter:** count_q is +1 on grant only, −1 on rvalid only, unchanged on both or neither.
- **FIFO full:** when full, mem_req_o is held 0 even if mem_rvalid_i is high that cycle. This keeps the rvalid→req path free of combinational logic.

## Timing
- **Latency:** zero-cycle combinational paths req→mem_req_o, mem_gnt_i→*_gnt_o, mem_rvalid_i→*_rvalid_o. No added latency.
- **Reset values:**
  - All outputs 0 during reset, except mem_be_o, which follows the muxed owner and may be all ones.
  - count_q=0, FIFO empty, `prio_q`=INSTR.
- **Throughput:** at most one grant per cycle. Back-to-back grants alternate between requesters while both request.
- **FIFO:** pointers wrap modulo MAX_OUTSTANDING.
- **Reset mid-operation:** pending tags and count are discarded. Late mem_rvalid_i after reset is treated as the empty-FIFO error.

## Structure
- Package `obi_arb_pkg`:
  - `arb_state_e` {ARB_IDLE, ARB_HOLD_INSTR, ARB_HOLD_DATA}
  - `owner_e` {OWNER_INSTR=1'b0, OWNER_DATA=1'b1}
- Sub-module `obi_arb_tag_fifo`:
  - Parameter DEPTH, 1-bit data.
  - Ports: push/pop/full/empty/head.
  - Instantiated once.
- Top holds the FSM, `prio_q`, count and muxes.

## Test plan
- **Single fetch:** instr_req_i=1 addr 0x80, mem_gnt_i=1 same cycle, rvalid next cycle with rdata 0x00310393 → instr_gnt_o=1 in cycle 0, instr_rvalid_o=1 with instr_rdata_o=0x00310393 in cycle 1, data_rvalid_o=0.
- **Simultaneous requests after reset:** both req, gnt always 1 → grant order INSTR, DATA, INSTR, DATA. mem_we_o/mem_be_o follow the owner; data write be=4'b0011 appears on mem_be_o.
- **Hold under stall:** data req addr 0x1000, mem_gnt_i=0 for 3 cycles while instr_req_i rises → mem_addr_o stays 0x1000, FSM in ARB_HOLD_DATA, data_gnt_o on cycle 4, instr not granted before.
- **Outstanding limit (MAX_OUTSTANDING=2):** two grants, no rvalid → mem_req_o=0 on the third cycle. One rvalid → mem_req_o=1 next cycle. Responses return to INSTR then DATA in grant order.
- **Error and reset cases:**
  - mem_rvalid_i with empty FIFO → no rvalid_o, assertion fires.
  - rst_ni low with 2 outstanding → count 0, outputs 0, `prio_q`=INSTR after release.

Source files
------------

// File: rtl/obi_arb_pkg.sv
// Shared types for the two-to-one OBI memory arbiter: FSM states, owner tags
// and a small helper that picks the opposite requester.
package obi_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE       = 2'd0,
    ARB_HOLD_INSTR = 2'd1,
    ARB_HOLD_DATA  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  function automatic owner_e other_owner(input owner_e owner);
    return (owner == OWNER_INSTR) ? OWNER_DATA : OWNER_INSTR;
  endfunction

endpackage

// File: rtl/obi_arb_tag_fifo.sv
// Owner-tag FIFO: remembers which requester each granted memory access belongs
// to so that in-order responses can be steered back to it.
module obi_arb_tag_fifo
  import obi_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_i,
  input  owner_e push_tag_i,
  input  logic   pop_i,
  output logic   full_o,
  output logic   empty_o,
  output owner_e head_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  owner_e           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign full_o  = (r_cnt == CNT_W'(DEPTH));
  assign empty_o = (r_cnt == '0);
  assign head_o  = r_mem[r_rd_ptr];

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is not reset; the reset pointers/count make stale entries unreachable.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= push_tag_i;
  end

endmodule

// File: rtl/obi_mem_arbiter.sv
// Round-robin two-to-one OBI arbiter letting the instruction and data ports
// share one single-ported memory, with in-order response routing.
module obi_mem_arbiter
  import obi_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    instr_req_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  owner_e           prio_q;
  owner_e           w_owner;
  owner_e           w_head;
  logic [CNT_W-1:0] count_q;
  logic             w_owner_req;
  logic             w_can_issue;
  logic             w_grant;
  logic             w_pop;
  logic             w_fifo_full;
  logic             w_fifo_empty;

  // Issue is gated on registered state only, so rvalid never reaches mem_req_o.
  assign w_can_issue = (count_q < CNT_W'(MAX_OUTSTANDING)) && !w_fifo_full;

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_owner     = OWNER_INSTR;
    w_state_nxt = ARB_IDLE;
    case (r_state)
      ARB_HOLD_INSTR: w_owner = OWNER_INSTR;
      ARB_HOLD_DATA:  w_owner = OWNER_DATA;
      default: begin
        if (instr_req_i && data_req_i) w_owner = prio_q;
        else if (data_req_i)           w_owner = OWNER_DATA;
      end
    endcase

    w_owner_req = (w_owner == OWNER_DATA) ? data_req_i : instr_req_i;
    mem_req_o   = w_owner_req && w_can_issue;
    w_grant     = mem_req_o && mem_gnt_i;

    if (mem_req_o && !mem_gnt_i)
      w_state_nxt = (w_owner == OWNER_DATA) ? ARB_HOLD_DATA : ARB_HOLD_INSTR;
    else if (r_state != ARB_IDLE && w_owner_req && !w_grant)
      w_state_nxt = r_state;  // held request blocked by the outstanding limit
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ARB_IDLE;
      prio_q  <= OWNER_INSTR;
      count_q <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) prio_q <= other_owner(w_owner);
      case ({w_grant, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign mem_addr_o  = (w_owner == OWNER_DATA) ? data_addr_i  : instr_addr_i;
  assign mem_we_o    = (w_owner == OWNER_DATA) && data_we_i;
  assign mem_be_o    = (w_owner == OWNER_DATA) ? data_be_i    : '1;
  assign mem_wdata_o = (w_owner == OWNER_DATA) ? data_wdata_i : '0;

  assign instr_gnt_o = w_grant && (w_owner == OWNER_INSTR);
  assign data_gnt_o  = w_grant && (w_owner == OWNER_DATA);

  assign w_pop          = mem_rvalid_i && !w_fifo_empty;
  assign instr_rvalid_o = w_pop && (w_head == OWNER_INSTR);
  assign data_rvalid_o  = w_pop && (w_head == OWNER_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  obi_arb_tag_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (w_grant),
    .push_tag_i (w_owner),
    .pop_i      (w_pop),
    .full_o     (w_fifo_full),
    .empty_o    (w_fifo_empty),
    .head_o     (w_head)
  );

  a_rvalid_with_pending : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(mem_rvalid_i && w_fifo_empty))
    else $warning("obi_mem_arbiter: mem_rvalid_i with no outstanding request");

  a_instr_hold_kept : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_state == ARB_HOLD_INSTR) |-> instr_req_i)
    else $warning("obi_mem_arbiter: instr_req_i dropped before grant");

  a_data_hold_kept : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_state == ARB_HOLD_DATA) |-> data_req_i)
    else $warning("obi_mem_arbiter: data_req_i dropped before grant");

endmodule
